// File: rtl/bg_tile_fetcher.sv
// bg_tile_fetcher: sequences map/tile-low/tile-high VRAM reads per background tile
// and hands each finished tile row to the pixel FIFO over a valid/ready handshake.
module bg_tile_fetcher #(
    parameter int FETCH_TILES = 21
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic        abort,
    input  logic [7:0]  ly,
    input  logic [7:0]  scx,
    input  logic [7:0]  scy,
    input  logic        map_sel,
    input  logic        data_sel,
    output logic [12:0] vram_addr,
    output logic        vram_oe,
    input  logic [7:0]  md_in,
    output logic [7:0]  tile_lo,
    output logic [7:0]  tile_hi,
    output logic        tile_valid,
    input  logic        tile_ready,
    output logic        busy,
    output logic [4:0]  tile_col
);
    typedef enum logic [2:0] {IDLE, MAP_A, MAP_B, LO_A, LO_B, HI_A, HI_B, PUSH} state_t;

    state_t     state;
    logic [7:0] y;
    logic [7:0] tn;
    logic [5:0] cnt;
    logic [7:0] y_new;

    assign y_new = ly + scy;

    // The address is registered on the edge entering each A state, so the
    // select bits are taken as they stand when that access is launched.
    function automatic logic [12:0] map_addr(input logic [7:0] yy, input logic [4:0] c);
        return {2'b11, map_sel, yy[7:3], c};
    endfunction

    function automatic logic [12:0] data_addr(input logic [7:0] t, input logic h);
        return {data_sel ? 1'b0 : ~t[7], t, y[2:0], h};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            y          <= '0;
            tn         <= '0;
            cnt        <= '0;
            vram_addr  <= '0;
            vram_oe    <= 1'b0;
            tile_lo    <= '0;
            tile_hi    <= '0;
            tile_valid <= 1'b0;
            busy       <= 1'b0;
            tile_col   <= '0;
        end else if (line_start) begin
            state      <= MAP_A;
            y          <= y_new;
            tile_col   <= scx[7:3];
            cnt        <= '0;
            tile_valid <= 1'b0;
            vram_oe    <= 1'b1;
            busy       <= 1'b1;
            vram_addr  <= map_addr(y_new, scx[7:3]);
        end else if (abort) begin
            state      <= IDLE;
            tile_valid <= 1'b0;
            vram_oe    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE:  state <= IDLE;
                MAP_A: state <= MAP_B;
                MAP_B: begin
                    tn        <= md_in;
                    vram_addr <= data_addr(md_in, 1'b0);
                    state     <= LO_A;
                end
                LO_A:  state <= LO_B;
                LO_B: begin
                    tile_lo   <= md_in;
                    vram_addr <= data_addr(tn, 1'b1);
                    state     <= HI_A;
                end
                HI_A:  state <= HI_B;
                HI_B: begin
                    tile_hi    <= md_in;
                    vram_oe    <= 1'b0;
                    tile_valid <= 1'b1;
                    state      <= PUSH;
                end
                PUSH: if (tile_ready) begin
                    tile_valid <= 1'b0;
                    tile_col   <= tile_col + 5'd1;
                    cnt        <= cnt + 6'd1;
                    if (cnt == 6'(FETCH_TILES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state     <= MAP_A;
                        vram_oe   <= 1'b1;
                        vram_addr <= map_addr(y, tile_col + 5'd1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bg_tile_fetcher.sv
// tb_bg_tile_fetcher: random VRAM contents and line parameters checked against a
// per-line model of expected VRAM accesses and tile rows.
module tb_bg_tile_fetcher;
    localparam int N = 21;

    logic        clk = 0;
    logic        reset;
    logic        line_start, abort;
    logic [7:0]  ly, scx, scy;
    logic        map_sel, data_sel;
    logic [12:0] vram_addr;
    logic        vram_oe;
    logic [7:0]  md_in;
    logic [7:0]  tile_lo, tile_hi;
    logic        tile_valid, tile_ready;
    logic        busy;
    logic [4:0]  tile_col;

    bg_tile_fetcher #(.FETCH_TILES(N)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .abort(abort),
        .ly(ly), .scx(scx), .scy(scy), .map_sel(map_sel), .data_sel(data_sel),
        .vram_addr(vram_addr), .vram_oe(vram_oe), .md_in(md_in),
        .tile_lo(tile_lo), .tile_hi(tile_hi), .tile_valid(tile_valid),
        .tile_ready(tile_ready), .busy(busy), .tile_col(tile_col)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [8192];
    logic [12:0] addr_q [$];
    logic [15:0] tile_q [$];
    logic [12:0] obs [8];
    int n_obs, oe_cnt, n_push, rdy_mode;
    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected accesses for a whole line, each address held for two cycles.
    task automatic build_model(input int l, input int sx, input int sy, input int ms, input int ds);
        int yy, c, ma, t, s, base, la;
        addr_q.delete();
        tile_q.delete();
        n_obs = 0;
        oe_cnt = 0;
        n_push = 0;
        yy = (l + sy) % 256;
        for (int k = 0; k < N; k++) begin
            c = (sx / 8 + k) % 32;
            ma = 'h1800 + ms * 'h400 + (yy / 8) * 32 + c;
            t = int'(mem[ma]);
            s = (t < 128) ? t : t - 256;
            base = ds ? t * 16 : 4096 + s * 16;
            la = base + (yy % 8) * 2;
            repeat (2) addr_q.push_back(13'(ma));
            repeat (2) addr_q.push_back(13'(la));
            repeat (2) addr_q.push_back(13'(la + 1));
            tile_q.push_back({mem[la + 1], mem[la]});
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] t;
        if (!reset) begin
            md_in = mem[vram_addr];
            tile_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (vram_oe) begin
                oe_cnt++;
                if (oe_cnt[0] && n_obs < 8) begin
                    obs[n_obs] = vram_addr;
                    n_obs++;
                end
                if (addr_q.size() == 0) check("addr_unexpected", {19'b0, vram_addr}, 32'hFFFFFFFF);
                else check("addr", {19'b0, vram_addr}, {19'b0, addr_q.pop_front()});
            end
            if (tile_valid && tile_ready) begin
                if (tile_q.size() == 0) check("tile_unexpected", {16'b0, tile_hi, tile_lo}, 32'hFFFFFFFF);
                else begin
                    t = tile_q.pop_front();
                    check("tile_lo", tile_lo, t[7:0]);
                    check("tile_hi", tile_hi, t[15:8]);
                end
                n_push++;
            end
        end
    end

    task automatic start_line(input logic [7:0] l, input logic [7:0] sx, input logic [7:0] sy,
                              input logic ms, input logic ds, input logic ab);
        @(negedge clk);
        ly = l; scx = sx; scy = sy; map_sel = ms; data_sel = ds;
        line_start = 1; abort = ab;
        build_model(l, sx, sy, ms, ds);
        @(negedge clk);
        line_start = 0; abort = 0;
    endtask

    task automatic start_rand(input logic ab);
        start_line(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), ab);
    endtask

    task automatic wait_idle(inout int n);
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (busy && n < 3000);
        check("busy_end", busy, 0);
        check("pushes", n_push, N);
        check("addr_left", addr_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, vram_addr, 0);
        check({tag, "_oe"}, vram_oe, 0);
        check({tag, "_lo"}, tile_lo, 0);
        check({tag, "_hi"}, tile_hi, 0);
        check({tag, "_valid"}, tile_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_col"}, tile_col, 0);
    endtask

    initial begin
        int n;
        logic [7:0] lo_s, hi_s;
        logic [7:0] tns [3] = '{8'h80, 8'h00, 8'h7F};
        logic [12:0] los [3] = '{13'h0800, 13'h1000, 13'h17F0};
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        reset = 1; line_start = 0; abort = 0; ly = 0; scx = 0; scy = 0;
        map_sel = 0; data_sel = 1; md_in = 0; tile_ready = 0; rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) reset = 0;

        // Basic line: latency, addresses and line length with ready high.
        mem['h1800] = 8'h05; mem['h0050] = 8'hA5; mem['h0051] = 8'h3C;
        start_line(0, 0, 0, 0, 1, 0);
        n = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            n++;
            #1 check("valid_cycle7", tile_valid, i == 6);
        end
        check("first_lo", tile_lo, 8'hA5);
        check("first_hi", tile_hi, 8'h3C);
        wait_idle(n);
        check("busy_fall_cycle", n, 147);
        check("obs_map0", obs[0], 13'h1800);
        check("obs_lo0", obs[1], 13'h0050);
        check("obs_hi0", obs[2], 13'h0051);

        // Signed tile data base.
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) begin
            mem['h1800] = tns[i];
            start_line(0, 0, 0, 0, 0, 0);
            n = 0;
            wait_idle(n);
            check("signed_lo_addr", obs[1], los[i]);
        end

        // Scrolled line with column wrap and map 1.
        mem['h1C1F] = 8'h01;
        start_line(8'h10, 8'hF8, 8'hF5, 1, 1, 0);
        n = 0;
        wait_idle(n);
        check("wrap_map0", obs[0], 13'h1C1F);
        check("wrap_lo", obs[1], 13'h001A);
        check("wrap_hi", obs[2], 13'h001B);
        check("wrap_map1", obs[3], 13'h1C00);

        // Back-pressure: PUSH holds while ready is low.
        rdy_mode = 2;
        start_rand(0);
        for (int i = 0; i < 20 && !tile_valid; i++) @(negedge clk);
        check("hold_reach", tile_valid, 1);
        lo_s = tile_lo; hi_s = tile_hi;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", tile_valid, 1);
            check("hold_oe", vram_oe, 0);
            check("hold_lo", tile_lo, lo_s);
            check("hold_hi", tile_hi, hi_s);
        end
        rdy_mode = 1;
        @(negedge clk);
        @(posedge clk);
        #1 check("release_oe", vram_oe, 1);
        check("release_valid", tile_valid, 0);
        n = 0;
        wait_idle(n);

        // Abort during LO_B.
        start_rand(0);
        repeat (3) @(posedge clk);
        #1 abort = 1;
        @(posedge clk);
        #1 abort = 0;
        check("abort_busy", busy, 0);
        check("abort_oe", vram_oe, 0);
        check("abort_valid", tile_valid, 0);
        repeat (3) @(posedge clk);
        #1 check("abort_pushes", n_push, 0);
        addr_q.delete(); tile_q.delete();

        // line_start with abort while a tile waits in PUSH restarts the line.
        rdy_mode = 2;
        start_rand(0);
        for (int i = 0; i < 20 && !tile_valid; i++) @(negedge clk);
        check("restart_reach", tile_valid, 1);
        start_line(8'h33, 8'h48, 8'h07, 0, 1, 1);
        rdy_mode = 0;
        check("restart_busy", busy, 1);
        check("restart_oe", vram_oe, 1);
        check("restart_valid", tile_valid, 0);
        check("restart_col", tile_col, 5'd9);
        n = 0;
        wait_idle(n);

        // Asynchronous reset during HI_A.
        rdy_mode = 1;
        start_rand(0);
        repeat (4) @(posedge clk);
        #2 reset = 1;
        #1 check_zero("async_reset");
        @(negedge clk) reset = 0;
        addr_q.delete(); tile_q.delete();

        // Random lines with random back-pressure.
        rdy_mode = 0;
        repeat (12) begin
            start_rand(0);
            n = 0;
            wait_idle(n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
